// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite encodings and the command record used by ahb_cmd_master.
//   - htrans_e      : HTRANS transfer types
//   - HSIZE_*       : HSIZE encodings supported by the command stream
//   - HBURST_SINGLE : the only burst type this initiator issues
//   - ahb_cmd_t     : one command (address, write data, size, direction)
//   - hsize_legal   : true when a size code is one this initiator may issue
// ----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        write;
    } ahb_cmd_t;

    // Sizes above a word are outside the 32-bit data bus.
    function automatic logic hsize_legal(input logic [2:0] size);
        return (size <= HSIZE_WORD);
    endfunction

endpackage

// File: rtl/ahb_wait_watchdog.sv
// ----------------------------------------------------------------------------
// ahb_wait_watchdog
//   Counts consecutive clock edges on which a data phase is pending (armed)
//   while the slave stretches it (hready low). When the run reaches
//   TIMEOUT_CYCLES the sticky timeout flag is raised; only reset clears it.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     armed      : a data phase is outstanding
//     hready     : AHB HREADY
//     timeout    : sticky flag, registered
// ----------------------------------------------------------------------------
module ahb_wait_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic armed,
    input  logic hready,
    output logic timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;
    logic          timeout_r;

    // Wait-state run counter (saturating) and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= '0;
            timeout_r <= 1'b0;
        end else if (armed && !hready) begin
            if (count_r != COUNT_MAX) begin
                count_r <= count_r + CW'(1);
            end
            // This edge is the TIMEOUT_CYCLES-th consecutive low edge.
            if (count_r == COUNT_LAST) begin
                timeout_r <= 1'b1;
            end
        end else begin
            count_r <= '0;
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/ahb_cmd_master.sv
// ----------------------------------------------------------------------------
// ahb_cmd_master
//   AHB-Lite initiator turning a valid/ready command stream into single
//   NONSEQ transfers, one response per command, in order.
//   Pipeline: AP (address phase) register -> DP (data phase) register.
//   An ERROR response parks any queued address phase in a replay buffer
//   and reissues it after the error completes, so nothing is dropped.
//   Ports:
//     HCLK, HRESETn                 : clock, asynchronous active-low reset
//     cmd_valid/ready/write/addr/size/wdata : command stream
//     rsp_valid/rdata/err           : one-cycle response pulse
//     busy                          : address or data phase in flight
//     timeout                       : sticky wait-state watchdog flag
//     HADDR..HWDATA, HREADY, HRDATA, HRESP : AHB-Lite master interface
// ----------------------------------------------------------------------------
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter logic [3:0]  HPROT_VAL      = 4'b0011,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        timeout,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    // Registered state
    ahb_cmd_t    ap_r;
    logic        ap_valid_r;
    htrans_e     htrans_r;
    logic        dp_valid_r;
    logic        dp_write_r;
    ahb_cmd_t    replay_r;
    logic        replay_valid_r;
    logic        err_hold_r;
    logic [31:0] hwdata_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        busy_r;

    // Next-state values
    ahb_cmd_t    ap_s;
    logic        ap_valid_s;
    logic        dp_valid_s;
    logic        dp_write_s;
    ahb_cmd_t    replay_s;
    logic        replay_valid_s;
    logic        err_hold_s;
    logic [31:0] hwdata_s;
    logic        rsp_valid_s;
    logic [31:0] rsp_rdata_s;
    logic        rsp_err_s;

    ahb_cmd_t    cmd_s;
    logic        cmd_ready_s;
    logic        cmd_accept_s;
    logic        err_start_s;

    assign cmd_s        = '{addr: cmd_addr, wdata: cmd_wdata, size: cmd_size, write: cmd_write};
    assign cmd_ready_s  = (!ap_valid_r || HREADY) && !err_hold_r && !replay_valid_r;
    assign cmd_accept_s = cmd_valid && cmd_ready_s;
    // First cycle of the two-cycle ERROR response.
    assign err_start_s  = dp_valid_r && !HREADY && HRESP && !err_hold_r;

    // Pipeline advance, error handling and response generation.
    always_comb begin
        ap_s           = ap_r;
        ap_valid_s     = ap_valid_r;
        dp_valid_s     = dp_valid_r;
        dp_write_s     = dp_write_r;
        replay_s       = replay_r;
        replay_valid_s = replay_valid_r;
        err_hold_s     = err_hold_r;
        hwdata_s       = hwdata_r;
        rsp_valid_s    = 1'b0;
        rsp_rdata_s    = rsp_rdata_r;
        rsp_err_s      = rsp_err_r;

        if (HREADY) begin
            // Data phase completes (normal or second ERROR cycle).
            if (dp_valid_r) begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = HRESP;
                rsp_rdata_s = dp_write_r ? 32'h0000_0000 : HRDATA;
            end else begin
                rsp_valid_s = 1'b0;
            end

            dp_valid_s = ap_valid_r;
            dp_write_s = ap_r.write;
            if (ap_valid_r) begin
                hwdata_s = ap_r.wdata;
            end else begin
                hwdata_s = hwdata_r;
            end
            err_hold_s = 1'b0;

            // A parked command goes out before anything new from the stream;
            // cmd_ready is low while one is parked, so no accept can collide.
            if (replay_valid_r) begin
                ap_s           = replay_r;
                ap_valid_s     = 1'b1;
                replay_valid_s = 1'b0;
            end else if (cmd_accept_s) begin
                ap_s       = cmd_s;
                ap_valid_s = 1'b1;
            end else begin
                ap_valid_s = 1'b0;
            end
        end else if (err_start_s) begin
            // Drive IDLE in the second error cycle; keep the pending address
            // phase (or a command accepted on this very edge) for reissue.
            err_hold_s = 1'b1;
            if (ap_valid_r) begin
                replay_s       = ap_r;
                replay_valid_s = 1'b1;
                ap_valid_s     = 1'b0;
            end else if (cmd_accept_s) begin
                replay_s       = cmd_s;
                replay_valid_s = 1'b1;
            end else begin
                replay_valid_s = replay_valid_r;
            end
        end else if (cmd_accept_s) begin
            // Only reachable with AP empty: start a new address phase while
            // the current data phase is being stretched.
            ap_s       = cmd_s;
            ap_valid_s = 1'b1;
        end else begin
            ap_valid_s = ap_valid_r;
        end
    end

    // State and AHB output registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_r           <= '0;
            ap_valid_r     <= 1'b0;
            htrans_r       <= HTRANS_IDLE;
            dp_valid_r     <= 1'b0;
            dp_write_r     <= 1'b0;
            replay_r       <= '0;
            replay_valid_r <= 1'b0;
            err_hold_r     <= 1'b0;
            hwdata_r       <= 32'h0000_0000;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 32'h0000_0000;
            rsp_err_r      <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            ap_r           <= ap_s;
            ap_valid_r     <= ap_valid_s;
            htrans_r       <= ap_valid_s ? HTRANS_NONSEQ : HTRANS_IDLE;
            dp_valid_r     <= dp_valid_s;
            dp_write_r     <= dp_write_s;
            replay_r       <= replay_s;
            replay_valid_r <= replay_valid_s;
            err_hold_r     <= err_hold_s;
            hwdata_r       <= hwdata_s;
            rsp_valid_r    <= rsp_valid_s;
            rsp_rdata_r    <= rsp_rdata_s;
            rsp_err_r      <= rsp_err_s;
            busy_r         <= ap_valid_s || dp_valid_s;
        end
    end

    ahb_wait_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .armed   (dp_valid_r),
        .hready  (HREADY),
        .timeout (timeout)
    );

    assign cmd_ready = cmd_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;
    assign HADDR     = ap_r.addr;
    assign HWRITE    = ap_r.write;
    assign HSIZE     = ap_r.size;
    assign HTRANS    = htrans_r;
    assign HWDATA    = hwdata_r;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;

endmodule
